// File: rtl/alu_status_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_status_unit_if
// Description : Signal bundle between the adder/control side and the ALU
//               status/trap stage. The master drives the ALU result and the
//               handshake acknowledge; the slave (status unit) returns the
//               flags, the overflow bookkeeping and the exception request.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_status_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  // Result side
  logic             op_valid;
  logic [WIDTH-1:0] s;
  logic             carry_out;
  logic             sig_O;
  // Control side
  logic             trap_en;
  logic             clr_sticky;
  logic             exc_ack;
  // Status outputs
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             flags_valid;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic             exc_req;
  logic             exc_lost;

  modport master (
    output op_valid, s, carry_out, sig_O, trap_en, clr_sticky, exc_ack,
    input  flag_n, flag_z, flag_c, flag_v, flags_valid,
           ovf_sticky, ovf_count, exc_req, exc_lost
  );

  modport slave (
    input  op_valid, s, carry_out, sig_O, trap_en, clr_sticky, exc_ack,
    output flag_n, flag_z, flag_c, flag_v, flags_valid,
           ovf_sticky, ovf_count, exc_req, exc_lost
  );
endinterface
`default_nettype wire

// File: rtl/alu_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_status_unit
// Description : Registered status/trap stage behind the 32-bit adder.
//               Captures N/Z/C/V, keeps a sticky overflow bit and a saturating
//               overflow counter, and raises an overflow exception request
//               to the control unit over a four-phase req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_status_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  wire               clk,
  input  wire               rst,
  alu_status_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic             flag_n_q, flag_z_q, flag_c_q, flag_v_q;
  logic             flags_valid_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lost_q, lost_d;
  logic             exc_req_q;

  logic             w_ovf_ev;
  logic [CNT_W-1:0] w_cnt_base;

  // Overflow bookkeeping: a same-cycle clear is applied first, then the event.
  always_comb begin
    w_ovf_ev   = bus.op_valid & bus.sig_O;
    w_cnt_base = bus.clr_sticky ? '0 : cnt_q;
    cnt_d      = w_cnt_base;
    if (w_ovf_ev && (w_cnt_base != C_CNT_MAX)) begin
      cnt_d = w_cnt_base + C_CNT_ONE;
    end
    sticky_d = w_ovf_ev | (sticky_q & ~bus.clr_sticky);
    lost_d   = lost_q & ~bus.clr_sticky;
    if (w_ovf_ev && (state_q != ST_IDLE)) begin
      lost_d = 1'b1;
    end
  end

  // Flag capture and overflow status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_n_q      <= 1'b0;
      flag_z_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      flag_v_q      <= 1'b0;
      flags_valid_q <= 1'b0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      lost_q        <= 1'b0;
    end else begin
      flags_valid_q <= bus.op_valid;
      if (bus.op_valid) begin
        flag_n_q <= bus.s[WIDTH-1];
        flag_z_q <= (bus.s == '0);
        flag_c_q <= bus.carry_out;
        flag_v_q <= bus.sig_O;
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
    end
  end

  // Exception handshake FSM; exc_req is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      exc_req_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // trap_en only matters here; a request is never withdrawn later.
          if (w_ovf_ev && bus.trap_en) begin
            state_q   <= ST_REQ;
            exc_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.exc_ack) begin
            state_q   <= ST_WAIT_REL;
            exc_req_q <= 1'b0;
          end
        end
        ST_WAIT_REL: begin
          if (!bus.exc_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          exc_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flag_n      = flag_n_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_v      = flag_v_q;
  assign bus.flags_valid = flags_valid_q;
  assign bus.ovf_sticky  = sticky_q;
  assign bus.ovf_count   = cnt_q;
  assign bus.exc_req     = exc_req_q;
  assign bus.exc_lost    = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_status_unit
// Description : Self-checking bench for alu_status_unit: a directed vector
//               table, hand-written corner sequences and randomized stimulus
//               compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_status_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic       n, z, c, v, fv, st;
    logic [7:0] cnt;
    logic       req, lost;
  } outs_t;

  typedef struct {
    logic        rst, op;
    logic [31:0] s;
    logic        c, v, tr, cl, ak;
    outs_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_status_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_status_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state plus "request outstanding" and
  // "waiting for ack release" booleans.
  outs_t m;
  bit    m_outstanding, m_releasing;
  int    m_count;

  function automatic outs_t mk_o(logic n, z, c, v, fv, st, logic [7:0] cnt, logic rq, lo);
    outs_t o;
    o.n = n; o.z = z; o.c = c; o.v = v; o.fv = fv; o.st = st;
    o.cnt = cnt; o.req = rq; o.lost = lo;
    return o;
  endfunction

  function automatic vec_t mk(logic r, op, logic [31:0] s, logic c, v, tr, cl, ak, outs_t e);
    vec_t t;
    t.rst = r; t.op = op; t.s = s; t.c = c; t.v = v;
    t.tr = tr; t.cl = cl; t.ak = ak; t.e = e;
    return t;
  endfunction

  task automatic model_update(logic r, op, logic [31:0] s, logic c, v, tr, cl, ak);
    bit ev;
    bit busy;
    if (r) begin
      m = mk_o(0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
      m_count = 0; m_outstanding = 0; m_releasing = 0;
      return;
    end
    ev   = op && v;
    busy = m_outstanding || m_releasing;
    m.fv = op;
    if (op) begin
      m.n = s[31];
      m.z = (s == 32'd0);
      m.c = c;
      m.v = v;
    end
    if (cl) begin
      m_count = 0; m.st = 0; m.lost = 0;
    end
    if (ev) begin
      m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      m.st = 1;
      if (busy) m.lost = 1;
    end
    m.cnt = m_count[7:0];
    if (m_outstanding) begin
      if (ak) begin m_outstanding = 0; m_releasing = 1; end
    end else if (m_releasing) begin
      if (!ak) m_releasing = 0;
    end else if (ev && tr) begin
      m_outstanding = 1;
    end
    m.req = m_outstanding;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(string tag, outs_t e);
    chk({tag, " flag_n"},      32'(bus.flag_n),      32'(e.n));
    chk({tag, " flag_z"},      32'(bus.flag_z),      32'(e.z));
    chk({tag, " flag_c"},      32'(bus.flag_c),      32'(e.c));
    chk({tag, " flag_v"},      32'(bus.flag_v),      32'(e.v));
    chk({tag, " flags_valid"}, 32'(bus.flags_valid), 32'(e.fv));
    chk({tag, " ovf_sticky"},  32'(bus.ovf_sticky),  32'(e.st));
    chk({tag, " ovf_count"},   32'(bus.ovf_count),   32'(e.cnt));
    chk({tag, " exc_req"},     32'(bus.exc_req),     32'(e.req));
    chk({tag, " exc_lost"},    32'(bus.exc_lost),    32'(e.lost));
  endtask

  // Drive inputs on the falling edge, let the rising edge capture them,
  // advance the model, and return 1 time unit after the edge.
  task automatic step(logic r, op, logic [31:0] s, logic c, v, tr, cl, ak);
    @(negedge clk);
    rst            = r;
    bus.op_valid   = op;
    bus.s          = s;
    bus.carry_out  = c;
    bus.sig_O      = v;
    bus.trap_en    = tr;
    bus.clr_sticky = cl;
    bus.exc_ack    = ak;
    @(posedge clk);
    model_update(r, op, s, c, v, tr, cl, ak);
    #1;
  endtask

  vec_t tbl[20];

  initial begin
    rst = 1'b1;
    bus.op_valid = 0; bus.s = '0; bus.carry_out = 0; bus.sig_O = 0;
    bus.trap_en = 0; bus.clr_sticky = 0; bus.exc_ack = 0;
    m = mk_o(0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    m_count = 0; m_outstanding = 0; m_releasing = 0;

    // rst op s c v tr cl ak | n z c v fv st cnt req lost
    tbl[0]  = mk(1, 0, 32'h0,        0, 0, 0, 0, 0, mk_o(0, 0, 0, 0, 0, 0, 8'd0, 0, 0));
    tbl[1]  = mk(0, 1, 32'h80000000, 0, 1, 1, 0, 0, mk_o(1, 0, 0, 1, 1, 1, 8'd1, 1, 0));
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(0, 0, 32'h0, 0, 0, 1, 0, 0, mk_o(1, 0, 0, 1, 0, 1, 8'd1, 1, 0));
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, mk_o(1, 0, 0, 1, 0, 1, 8'd1, 0, 0));
    tbl[8]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, mk_o(1, 0, 0, 1, 0, 1, 8'd1, 0, 0));
    tbl[9]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, mk_o(1, 0, 0, 1, 0, 1, 8'd1, 0, 0));
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, mk_o(1, 0, 0, 1, 0, 1, 8'd1, 0, 0));
    tbl[11] = mk(0, 1, 32'h00000005, 0, 1, 1, 0, 0, mk_o(0, 0, 0, 1, 1, 1, 8'd2, 1, 0));
    tbl[12] = mk(0, 1, 32'h00000000, 1, 0, 1, 0, 0, mk_o(0, 1, 1, 0, 1, 1, 8'd2, 1, 0));
    tbl[13] = mk(0, 1, 32'h80000000, 1, 1, 1, 0, 0, mk_o(1, 0, 1, 1, 1, 1, 8'd3, 1, 1));
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, mk_o(1, 0, 1, 1, 0, 1, 8'd3, 0, 1));
    tbl[15] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, mk_o(1, 0, 1, 1, 0, 1, 8'd3, 0, 1));
    tbl[16] = mk(0, 1, 32'h00000000, 1, 0, 1, 0, 0, mk_o(0, 1, 1, 0, 1, 1, 8'd3, 0, 1));
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, mk_o(0, 1, 1, 0, 0, 0, 8'd0, 0, 0));
    tbl[18] = mk(0, 1, 32'h00000000, 0, 1, 0, 0, 0, mk_o(0, 1, 0, 1, 1, 1, 8'd1, 0, 0));
    tbl[19] = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, mk_o(0, 1, 0, 1, 0, 1, 8'd1, 0, 0));

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].s, tbl[i].c, tbl[i].v,
           tbl[i].tr, tbl[i].cl, tbl[i].ak);
      compare_all($sformatf("vec%0d", i), tbl[i].e);
    end

    // Clear/overflow collision with a count of 7 and exc_lost set.
    step(0, 0, 32'h0, 0, 0, 0, 1, 0);
    step(0, 1, 32'h1, 0, 1, 1, 0, 0);
    step(0, 1, 32'h1, 0, 1, 1, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h2, 0, 1, 0, 0, 0);
    compare_all("pre_collide", m);
    chk("pre_collide count", 32'(bus.ovf_count), 32'd7);
    chk("pre_collide lost", 32'(bus.exc_lost), 32'd1);
    step(0, 1, 32'h2, 0, 1, 0, 1, 0);
    compare_all("collide", m);
    chk("collide count", 32'(bus.ovf_count), 32'd1);
    chk("collide sticky", 32'(bus.ovf_sticky), 32'd1);
    chk("collide lost", 32'(bus.exc_lost), 32'd0);
    step(0, 0, 32'h0, 0, 0, 0, 1, 0);
    chk("clr count", 32'(bus.ovf_count), 32'd0);
    chk("clr sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("clr lost", 32'(bus.exc_lost), 32'd0);

    // Saturation: 300 overflow events must stop at all-ones.
    for (int i = 0; i < 300; i++) step(0, 1, 32'h7FFFFFFF, 0, 1, 0, 0, 0);
    chk("sat count", 32'(bus.ovf_count), 32'(CNT_MAX));
    step(0, 1, 32'h7FFFFFFF, 0, 1, 0, 0, 0);
    chk("sat hold", 32'(bus.ovf_count), 32'(CNT_MAX));
    compare_all("sat", m);

    // Reset in the middle of a request with nonzero flags.
    step(0, 1, 32'h80000000, 1, 1, 1, 0, 0);
    chk("midreq req", 32'(bus.exc_req), 32'd1);
    step(1, 0, 32'h0, 0, 0, 1, 0, 0);
    compare_all("rst_midreq", mk_o(0, 0, 0, 0, 0, 0, 8'd0, 0, 0));
    step(0, 0, 32'h0, 0, 0, 1, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1, 0, 1);
    compare_all("ack_after_rst", mk_o(0, 0, 0, 0, 0, 0, 8'd0, 0, 0));

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs;
      int sel;
      sel = int'($urandom_range(0, 3));
      rs = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h80000000 : $urandom;
      step(($urandom_range(0, 63) == 0), 1'($urandom), rs, 1'($urandom),
           ($urandom_range(0, 2) == 0), 1'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
      compare_all($sformatf("rnd%0d", i), m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
